instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage for the RISC-V core, sitting directly upstream of the control decoder. Owns the program counter, issues one word-aligned request at a time to instruction memory over a valid/ready request channel, and holds the returned instruction until the execute side consumes it. Presents `op` (instr[6:0]) to the main decoder and computes the next PC from the consumed instruction's redirect (branch taken / jump).

## Interface
- `XLEN`, 32, datapath/address width
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_addr`  out  XLEN  fetch address (= `pc`)
- `imem_req_ready`  in  1  memory accepts request
- `imem_rsp_valid`  in  1  response data valid (single-cycle pulse)
- `imem_rsp_data`  in  32  fetched instruction word
- `instr_valid`  out  1  `instr`/`pc` hold a fetched instruction
- `instr_ready`  in  1  execute side consumes instruction this cycle
- `instr`  out  32  held instruction
- `op`  out  7  `instr[6:0]`, to main decoder
- `pc`  out  XLEN  address of current/held instruction
- `pc_plus4`  out  XLEN  `pc + 4`, to result mux (jal link)
- `pc_src`  in  1  1 = redirect to `pc_target` (Branch&Zero | Jump); sampled only on consume
- `pc_target`  in  XLEN  branch/jump target
- `misalign`  out  1  sticky: a taken redirect had `pc_target[1:0] != 0`
- `retired_cnt`  out  32  instructions consumed since reset

## Operation
- States: IDLE, REQ, WAIT, HOLD. Reset state IDLE.
- IDLE: one cycle, -> REQ unconditionally.
- REQ: `imem_req_valid=1`, `imem_req_addr=pc`, both stable until accepted. On `imem_req_valid && imem_req_ready` -> WAIT.
- WAIT: on `imem_rsp_valid`, register `imem_rsp_data` into `instr` -> HOLD.
- HOLD: `instr_valid=1`. On `instr_ready`: `pc <= pc_src ? {pc_target[XLEN-1:2],2'b00} : pc + 4`; `retired_cnt <= retired_cnt + 1`; -> REQ.
- `pc_src`/`pc_target` ignored in every state except HOLD with `instr_ready=1`.
- Misaligned taken redirect: low two bits forced to 0, `misalign` set and held until reset.
- `imem_rsp_valid` in IDLE, REQ or HOLD is dropped (no state or data change).
- `instr_ready` outside HOLD is ignored; no consume, no count.
- At most one outstanding request; no speculative next-PC fetch.
- PC and `pc_plus4` arithmetic modulo 2^XLEN (0xFFFF_FFFC + 4 = 0). `retired_cnt` wraps 0xFFFF_FFFF -> 0.
- `op` and `pc_plus4` are combinational from registered `instr`/`pc`.

## Timing
- Reset values (asynchronous, while `rst_n=0`): state IDLE, `pc=RESET_PC`, `instr=32'h0000_0013` (nop), `instr_valid=0`, `imem_req_valid=0`, `misalign=0`, `retired_cnt=0`.
- First request: `imem_req_valid` rises in the 2nd cycle after `rst_n` deasserts (IDLE occupies the 1st).
- Request accepted in cycle N -> earliest response N+1 -> `instr_valid` in N+2.
- Consume in cycle M -> new `pc` and `imem_req_valid` visible in M+1.
- Best case (ready always 1, 1-cycle memory): one instruction per 3 cycles.
- `instr`, `pc`, `op` stable for the whole of HOLD.
- Reset asserted mid-request/mid-wait: all state returns to reset values immediately; a response arriving after reset release is dropped because state is not WAIT.

## Test plan
- Reset release, `imem_req_ready=1`, 1-cycle memory returning 0x00500093 at 0x0: req at cycle 2 addr 0x0, `instr_valid` at cycle 4, `op=7'b0010011`, `pc_plus4=0x4`.
- Four sequential consumes with `pc_src=0`: request addresses 0x0,0x4,0x8,0xC; `retired_cnt=4`.
- Consume at pc 0x8 with `pc_src=1`, `pc_target=0x40`: next request addr 0x40; `pc_src=1` pulsed during WAIT has no effect.
- `imem_req_ready` low for 5 cycles: `imem_req_valid=1` and addr unchanged throughout; `imem_rsp_valid` pulse during REQ dropped, `instr` unchanged.
- Redirect with `pc_target=0x102`: next addr 0x100, `misalign=1` and stays 1 across later fetches until reset.
- Assert `rst_n=0` in WAIT, release, then pulse `imem_rsp_valid` in IDLE: dropped; first request addr = `RESET_PC`, `retired_cnt=0`.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the program counter, issues one word-aligned
// request at a time to instruction memory and holds the returned word until
// the execute side consumes it. The next PC is chosen when the word is consumed.
module instr_fetch_unit #(
  parameter int unsigned          XLEN     = 32,
  parameter logic [XLEN-1:0]      RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [6:0]      op,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
  output logic            misalign,
  output logic [31:0]     retired_cnt
);

  localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t          state_r;
  logic [XLEN-1:0] pc_r;
  logic [31:0]     instr_r;
  logic            instr_valid_r;
  logic            req_valid_r;
  logic            misalign_r;
  logic [31:0]     retired_cnt_r;

  logic [XLEN-1:0] pc_plus4_s;
  logic [XLEN-1:0] next_pc_s;
  logic            misalign_hit_s;

  assign pc_plus4_s     = pc_r + PC_STEP;
  assign imem_req_valid = req_valid_r;
  assign imem_req_addr  = pc_r;
  assign instr_valid    = instr_valid_r;
  assign instr          = instr_r;
  assign op             = instr_r[6:0];
  assign pc             = pc_r;
  assign pc_plus4       = pc_plus4_s;
  assign misalign       = misalign_r;
  assign retired_cnt    = retired_cnt_r;

  // Next PC on consume: aligned redirect target when taken, otherwise pc+4.
  always_comb begin
    next_pc_s      = pc_plus4_s;
    misalign_hit_s = 1'b0;
    if (pc_src) begin
      next_pc_s      = {pc_target[XLEN-1:2], 2'b00};
      misalign_hit_s = (pc_target[1:0] != 2'b00);
    end else begin
      next_pc_s      = pc_plus4_s;
      misalign_hit_s = 1'b0;
    end
  end

  // Fetch FSM with all architectural state and handshake outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      pc_r          <= RESET_PC;
      instr_r       <= NOP_INSTR;
      instr_valid_r <= 1'b0;
      req_valid_r   <= 1'b0;
      misalign_r    <= 1'b0;
      retired_cnt_r <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r     <= REQ;
          req_valid_r <= 1'b1;
        end
        REQ: begin
          // Address is pc_r, which cannot change here, so it stays stable.
          if (req_valid_r && imem_req_ready) begin
            state_r     <= WAIT;
            req_valid_r <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            instr_r       <= imem_rsp_data;
            instr_valid_r <= 1'b1;
            state_r       <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            pc_r          <= next_pc_s;
            retired_cnt_r <= retired_cnt_r + 32'd1;
            misalign_r    <= misalign_r | misalign_hit_s;
            instr_valid_r <= 1'b0;
            req_valid_r   <= 1'b1;
            state_r       <= REQ;
          end
        end
        default: begin
          state_r       <= IDLE;
          instr_valid_r <= 1'b0;
          req_valid_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a behavioural one-cycle memory,
// a table of consume/redirect vectors and hand-written reset/stall sequences.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        misalign;
  logic [31:0] retired_cnt;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .op(op), .pc(pc),
    .pc_plus4(pc_plus4), .pc_src(pc_src), .pc_target(pc_target),
    .misalign(misalign), .retired_cnt(retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        src;
    logic [31:0] tgt;
    logic [31:0] exp_next;
    logic        exp_mis;
    int          stall;
    logic        rsp_glitch;
    logic        wait_glitch;
  } vec_t;

  vec_t        vecs[11];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];
  int          n_cmp;
  int          n_fail;
  logic [31:0] model_pc;
  logic [31:0] model_cnt;
  logic        model_mis;
  logic [31:0] last_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0050_0093;
    return {a[24:0], 7'b0110011};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete fetch: wait for the request, optional stall, accept, respond.
  task automatic do_fetch(input int stall, input logic rsp_glitch, input logic wait_glitch);
    int          t;
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] e;
    logic [6:0]  eop;
    t = 0;
    while (!imem_req_valid && t < 20) begin
      step();
      t++;
    end
    check("req_seen", {31'd0, imem_req_valid}, 32'd1);
    a = imem_req_addr;
    imem_req_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      if (rsp_glitch && i == 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
      end
      step();
      imem_rsp_valid = 1'b0;
      check("stall_valid", {31'd0, imem_req_valid}, 32'd1);
      check("stall_addr", imem_req_addr, a);
      if (rsp_glitch) check("req_rsp_dropped", instr, last_instr);
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    if (exp_addr_q.size() == 0) check("addr_q_empty", 32'd1, 32'd0);
    else begin
      e = exp_addr_q.pop_front();
      check("req_addr", a, e);
    end
    check("req_dropped", {31'd0, imem_req_valid}, 32'd0);
    if (wait_glitch) begin
      instr_ready = 1'b1;
      pc_src      = 1'b1;
      pc_target   = 32'h0000_0200;
      step();
      instr_ready = 1'b0;
      pc_src      = 1'b0;
      check("wait_no_valid", {31'd0, instr_valid}, 32'd0);
      check("wait_pc", pc, a);
      check("wait_cnt", retired_cnt, model_cnt);
    end
    w = mem_word(a);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = w;
    exp_instr_q.push_back(w);
    step();
    imem_rsp_valid = 1'b0;
    check("instr_valid", {31'd0, instr_valid}, 32'd1);
    e = exp_instr_q.pop_front();
    check("instr", instr, e);
    eop = e[6:0];
    check("op", {25'd0, op}, {25'd0, eop});
    check("pc", pc, a);
    check("pc_plus4", pc_plus4, a + 32'd4);
    last_instr = e;
    step();
    check("hold_instr", instr, e);
    check("hold_pc", pc, a);
    check("hold_valid", {31'd0, instr_valid}, 32'd1);
  endtask

  // Consume the held instruction and check the resulting architectural state.
  task automatic consume(input logic src, input logic [31:0] tgt,
                         input logic [31:0] exp_next, input logic exp_mis);
    instr_ready = 1'b1;
    pc_src      = src;
    pc_target   = tgt;
    model_cnt   = model_cnt + 32'd1;
    exp_addr_q.push_back(exp_next);
    step();
    instr_ready = 1'b0;
    pc_src      = 1'b0;
    pc_target   = 32'h0;
    check("next_pc", pc, exp_next);
    check("next_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("consumed_valid", {31'd0, instr_valid}, 32'd0);
    check("retired_cnt", retired_cnt, model_cnt);
    check("misalign", {31'd0, misalign}, {31'd0, exp_mis});
    model_pc = exp_next;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0000_0004, 1'b0, 0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0000, 32'h0000_0008, 1'b0, 0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 32'h0000_0000, 32'h0000_000C, 1'b0, 0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0000, 32'h0000_0010, 1'b0, 5, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0040, 32'h0000_0040, 1'b0, 0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0102, 32'h0000_0100, 1'b1, 0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0000_0104, 1'b1, 2, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b1, 0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0000_0004, 1'b1, 0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_0021, 32'h0000_0020, 1'b1, 1, 1'b0, 1'b0};

    n_cmp = 0; n_fail = 0;
    model_pc = 32'h0; model_cnt = 32'h0; model_mis = 1'b0;
    last_instr = 32'h0000_0013;
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0; instr_ready = 1'b0; pc_src = 1'b0; pc_target = 32'h0;
    step(); step();
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    check("rst_cnt", retired_cnt, 32'd0);

    // Release: IDLE occupies cycle 1, request visible in cycle 2.
    rst_n = 1'b1;
    imem_req_ready = 1'b0;
    #1;
    check("idle_no_req", {31'd0, imem_req_valid}, 32'd0);
    step();
    check("first_req", {31'd0, imem_req_valid}, 32'd1);
    check("first_addr", imem_req_addr, 32'h0);
    exp_addr_q.push_back(32'h0);

    for (int k = 0; k < 11; k++) begin
      do_fetch(vecs[k].stall, vecs[k].rsp_glitch, vecs[k].wait_glitch);
      consume(vecs[k].src, vecs[k].tgt, vecs[k].exp_next, vecs[k].exp_mis);
    end

    // Reset while waiting for a response; a late response must be dropped.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("midrst_pc", pc, 32'h0);
    check("midrst_misalign", {31'd0, misalign}, 32'd0);
    check("midrst_cnt", retired_cnt, 32'd0);
    step();
    rst_n = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0BAD_0BAD;
    step();
    imem_rsp_valid = 1'b0;
    check("late_rsp_instr", instr, 32'h0000_0013);
    check("late_rsp_valid", {31'd0, instr_valid}, 32'd0);
    check("post_rst_req", {31'd0, imem_req_valid}, 32'd1);
    check("post_rst_addr", imem_req_addr, 32'h0);

    exp_addr_q.delete();
    exp_instr_q.delete();
    exp_addr_q.push_back(32'h0);
    model_pc = 32'h0; model_cnt = 32'h0; last_instr = 32'h0000_0013;

    // Redirect from pc 0x8 to 0x40 after reset; misalign stays cleared.
    do_fetch(0, 1'b0, 1'b0);
    consume(1'b0, 32'h0, 32'h0000_0004, 1'b0);
    do_fetch(0, 1'b0, 1'b0);
    consume(1'b0, 32'h0, 32'h0000_0008, 1'b0);
    do_fetch(0, 1'b0, 1'b1);
    consume(1'b1, 32'h0000_0040, 32'h0000_0040, 1'b0);
    do_fetch(0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
